// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: drives an external single-position shifter once per
// cycle until the requested amount is consumed, then pulses done for one cycle.
module shift_sequencer #(
   parameter int DATA_W = 16,
   parameter int AMT_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [AMT_W-1:0]  amount,
   input  logic [DATA_W-1:0] din,
   input  logic [DATA_W-1:0] sh_out,
   output logic [DATA_W-1:0] sh_bin,
   output logic [1:0]        sh_shift,
   output logic [DATA_W-1:0] dout,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [DATA_W-1:0]  work, work_n;
   logic [AMT_W-1:0]   cnt, cnt_n;
   logic [1:0]         op_r, op_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         work  <= '0;
         cnt   <= '0;
         op_r  <= '0;
      end else begin
         state <= state_n;
         work  <= work_n;
         cnt   <= cnt_n;
         op_r  <= op_n;
      end
   end

   always_comb begin
      state_n = state;
      work_n  = work;
      cnt_n   = cnt;
      op_n    = op_r;
      case (state)
         IDLE: begin
            if (start) begin
               work_n = din;
               cnt_n  = amount;
               op_n   = op;
               // A zero amount or pass-through code needs no shifter cycles
               state_n = (amount == '0 || op == 2'b00) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            work_n = sh_out;
            cnt_n  = cnt - AMT_W'(1);
            if (cnt == AMT_W'(1)) state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign sh_bin   = work;
   assign sh_shift = (state == SHIFT) ? op_r : 2'b00;
   assign dout     = work;
   assign busy     = (state == SHIFT) || (state == DONE);
   assign done     = (state == DONE);

endmodule
